// File: rtl/snn_config_loader.sv
// snn_config_loader: framed byte-stream writer for the delay-SNN parameter buses.
// Bytes land in a shadow image. A completed frame copies the shadow into the
// active output registers in one cycle, so the network never sees a partial update.
module snn_config_loader #(
  parameter int unsigned W_BITS         = 288,
  parameter int unsigned D_BITS         = 576,
  parameter int unsigned NUM_BYTES      = 110,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [W_BITS-1:0] weights,
  output logic [D_BITS-1:0] delays,
  output logic [4:0]        threshold,
  output logic [2:0]        decay,
  output logic [4:0]        refractory_period,
  output logic              cfg_busy,
  output logic              cfg_update,
  output logic              cfg_error
);

  localparam int unsigned W_BYTES = W_BITS / 8;
  localparam int unsigned D_BYTES = D_BITS / 8;
  localparam int unsigned TH_BYTE = W_BYTES + D_BYTES;
  localparam int unsigned RP_BYTE = TH_BYTE + 1;
  localparam int unsigned IDX_W   = $clog2(NUM_BYTES);
  localparam int unsigned TMO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_DISCARD,
    S_COMMIT
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             addr_q, addr_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  // Bytes 0..TH_BYTE are kept whole. Only the 5 used bits of the refractory byte are stored.
  logic [TH_BYTE:0][7:0]  shadow_q, shadow_d;
  logic [4:0]             rp_sh_q, rp_sh_d;
  logic                   ready_q, busy_q, upd_q, err_q;
  logic                   upd_d, err_d;
  logic [W_BITS-1:0]      weights_q;
  logic [D_BITS-1:0]      delays_q;
  logic [4:0]             threshold_q;
  logic [2:0]             decay_q;
  logic [4:0]             rp_q;

  logic                   accept;
  logic                   timed;
  logic                   tmo_hit;
  logic                   len_ok;
  logic [8:0]             span;
  logic [IDX_W-1:0]       idx;

  // Next-state, shadow write and timeout logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    shadow_d = shadow_q;
    rp_sh_d  = rp_sh_q;
    upd_d    = 1'b0;
    err_d    = 1'b0;

    accept  = in_valid && (state_q != S_COMMIT);
    timed   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_DISCARD);
    span    = {1'b0, addr_q} + {1'b0, in_data};
    len_ok  = !addr_q[7] && (span <= 9'(NUM_BYTES));
    idx     = IDX_W'(addr_q);
    tmo_hit = (TIMEOUT_CYCLES != 0) && timed && !in_valid &&
              (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    if (accept) begin
      tmo_d = '0;
    end else if (timed) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = in_data;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (accept) begin
          cnt_d = in_data;
          if (len_ok) begin
            state_d = (in_data == 8'd0) ? S_COMMIT : S_DATA;
          end else if (in_data == 8'd0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DISCARD;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          if (idx == IDX_W'(RP_BYTE)) begin
            rp_sh_d = in_data[4:0];
          end else begin
            shadow_d[idx] = in_data;
          end
          addr_d = addr_q + 8'd1;
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = S_COMMIT;
          end
        end
      end
      S_DISCARD: begin
        if (accept) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_COMMIT: begin
        upd_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (tmo_hit) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end

    if (state_d == S_IDLE || state_d == S_COMMIT) begin
      tmo_d = '0;
    end
  end

  // State, shadow and registered outputs; active image loads only while in COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      shadow_q    <= '0;
      rp_sh_q     <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      upd_q       <= 1'b0;
      err_q       <= 1'b0;
      weights_q   <= '0;
      delays_q    <= '0;
      threshold_q <= '0;
      decay_q     <= '0;
      rp_q        <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      shadow_q <= shadow_d;
      rp_sh_q  <= rp_sh_d;
      ready_q  <= (state_d != S_COMMIT);
      busy_q   <= (state_d != S_IDLE);
      upd_q    <= upd_d;
      err_q    <= err_d;
      if (state_q == S_COMMIT) begin
        weights_q   <= shadow_q[W_BYTES-1:0];
        delays_q    <= shadow_q[TH_BYTE-1:W_BYTES];
        threshold_q <= shadow_q[TH_BYTE][4:0];
        decay_q     <= shadow_q[TH_BYTE][7:5];
        rp_q        <= rp_sh_q;
      end
    end
  end

  assign in_ready          = ready_q;
  assign cfg_busy          = busy_q;
  assign cfg_update        = upd_q;
  assign cfg_error         = err_q;
  assign weights           = weights_q;
  assign delays            = delays_q;
  assign threshold         = threshold_q;
  assign decay             = decay_q;
  assign refractory_period = rp_q;

endmodule

// File: doc/snn_config_loader.md
Name: snn_config_loader

Overview:
- Byte-stream configuration writer that drives the wide parameter buses of the delay-SNN top: weights, delays, threshold, decay and refractory_period.
- A host (SPI/UART bridge) streams framed byte writes into a shadow image.
- On frame completion the shadow image is committed atomically to the active output registers, so the network never sees a half-written configuration.
- Sits between the host bridge and the SNN top.

Parameters:
- W_BITS, 288, weight image width ((64+64+16)*2).
- D_BITS, 576, delay image width ((64+64+16)*4).
- NUM_BYTES, 110, total image bytes: 36 weight + 72 delay + 2 scalar.
- TIMEOUT_CYCLES, 1024, idle cycles mid-frame before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_data  in  8  host byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte; a byte transfers when in_valid && in_ready
- weights  out  W_BITS  active weight image
- delays  out  D_BITS  active delay image
- threshold  out  5  active threshold
- decay  out  3  active decay
- refractory_period  out  5  active refractory period
- cfg_busy  out  1  a frame is in progress (state != IDLE)
- cfg_update  out  1  one-cycle pulse in the first cycle the new active values are visible
- cfg_error  out  1  one-cycle pulse on a rejected or aborted frame

Behaviour:
- Reset (synchronous, active-high): FSM=IDLE; shadow and active images all zero; in_ready=1; cfg_busy=0; cfg_update=0; cfg_error=0. Reset mid-frame discards the frame and commits nothing.
- Byte map (byte k covers image bits [8k+7:8k]):
  - Bytes 0..35 map to weights, LSB first.
  - Bytes 36..107 map to delays.
  - Byte 108: threshold = [4:0], decay = [7:5].
  - Byte 109: refractory_period = [4:0]; bits [7:5] are ignored and read as 0.
- Frame format: ADDR byte, then LEN byte, then LEN data bytes.
  - ADDR[7] must be 0. Start byte index = ADDR[6:0].
- FSM states: IDLE, LEN, DATA, DISCARD, COMMIT.
  - IDLE: an accepted byte is latched as addr. Go to LEN. cfg_busy rises the next cycle.
  - LEN: an accepted byte is latched as len. Valid iff ADDR[7]==0 && addr+len <= NUM_BYTES, using 8-bit addr+len with no wrap, i.e. compare at 9 bits.
    - valid && len==0: go to COMMIT (commit-only frame).
    - valid && len>0: go to DATA, remaining count = len.
    - invalid && len==0: pulse cfg_error; go to IDLE.
    - invalid && len>0: go to DISCARD, remaining count = len.
  - DATA: each accepted byte writes shadow[addr], then addr++ and count--. After the byte with count==1, go to COMMIT.
  - DISCARD: each accepted byte is dropped and count--. After the last byte, pulse cfg_error and go to IDLE. Shadow is untouched.
  - COMMIT: exactly one cycle. in_ready=0. Active registers load from shadow at the end of this cycle. Next state is IDLE, and cfg_update=1 in that next cycle.
- in_ready=1 in every state except COMMIT. Throughput is 1 byte/cycle. Latency from the last data byte accepted to cfg_update is 2 cycles.
- Shadow persists across frames, so partial updates merge with earlier writes.
- Timeout: in LEN/DATA/DISCARD, a counter of consecutive cycles with in_valid=0 runs. When it reaches TIMEOUT_CYCLES: pulse cfg_error, go to IDLE, no commit. Bytes already written to shadow remain there, but active registers are unchanged. The counter clears on every accepted byte.
- Simultaneous events: reset has priority over everything. A timeout and an accepted byte can never coincide, because the count only advances on in_valid=0.
- Active outputs change only on commit or reset. They are registered and glitch-free toward the network.

Test Plan:
- Reset, then ADDR=0x6C, LEN=2, data 0xB3, 0x1F -> cfg_update pulse exactly 2 cycles after the last byte; threshold=5'h13, decay=3'h5, refractory_period=5'h1F; weights/delays=0.
- ADDR=0x00, LEN=36, bytes 0xFF -> weights all ones, delays unchanged. Then ADDR=0x24, LEN=1, byte 0xAB -> delays[7:0]=0xAB, weights still all ones.
- ADDR=0x6D, LEN=2, 2 data bytes -> both bytes discarded, one cfg_error pulse, no cfg_update, outputs unchanged. ADDR=0x80, LEN=0 -> cfg_error on the LEN byte, FSM back in IDLE.
- ADDR=0x10, LEN=0 -> cfg_update pulse with no data bytes; active images equal the current shadow.
- TIMEOUT_CYCLES=16: ADDR=0x00, LEN=4, 2 bytes, then in_valid=0 for 16 cycles -> cfg_error pulse, cfg_busy falls, active unchanged. A following commit-only frame exposes the 2 partial bytes.
- Assert reset mid-DATA after 3 of 10 bytes -> all outputs zero next cycle; a new frame is accepted immediately; in_ready stays high except in COMMIT cycles.
